// File: rtl/ram_seq.sv
// ram_seq: moves an N-bit host word to or from a 1-bit-wide RAM, two cycles per bit, LSB first.
// Optional build macro RAM_SEQ_VERIFY_EN adds a read-back pass and mismatch flag to every write.
module ram_seq #(
  parameter int AW = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 wr,
  input  logic [(1<<AW)-1:0]   wdata,
  output logic                 busy,
  output logic                 done,
  output logic [(1<<AW)-1:0]   rdata,
  output logic                 err,
  output logic [AW-1:0]        mem_addr,
  output logic                 mem_d,
  output logic                 mem_we,
  input  logic                 mem_q
);

  localparam int N = 1 << AW;
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    SAMPLE,
    DONE
  } state_t;

  function automatic logic [N-1:0] put_bit(input logic [N-1:0] word,
                                           input logic [AW-1:0] idx,
                                           input logic          b);
    logic [N-1:0] w;
    w      = word;
    w[idx] = b;
    return w;
  endfunction

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          wr_q, wr_d;
  logic [N-1:0]  wdata_q, wdata_d;
  logic [N-1:0]  rdata_d;
  logic          busy_d, done_d, mem_we_d, mem_d_d;
  logic [AW-1:0] addr_d;
  logic          do_write;

`ifdef RAM_SEQ_VERIFY_EN
  logic verify_q, verify_d;
  logic err_q, err_d;

  // Once the write pass is finished the same latched op walks the RAM again as a read.
  assign do_write = wr_q & ~verify_q;
  assign err      = err_q;
`else
  assign do_write = wr_q;
  assign err      = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    rdata_d = rdata;
`ifdef RAM_SEQ_VERIFY_EN
    verify_d = verify_q;
    err_d    = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETUP;
          idx_d   = '0;
          wr_d    = wr;
          wdata_d = wdata;
`ifdef RAM_SEQ_VERIFY_EN
          verify_d = 1'b0;
`endif
        end
      end

      SETUP: state_d = do_write ? STROBE : SAMPLE;

      STROBE: begin
        if (idx_q == LAST) begin
          idx_d = '0;
`ifdef RAM_SEQ_VERIFY_EN
          verify_d = 1'b1;
          state_d  = SETUP;
`else
          state_d = DONE;
`endif
        end else begin
          idx_d   = idx_q + AW'(1);
          state_d = SETUP;
        end
      end

      SAMPLE: begin
        rdata_d = put_bit(rdata, idx_q, mem_q);
        if (idx_q == LAST) begin
          idx_d   = '0;
          state_d = DONE;
`ifdef RAM_SEQ_VERIFY_EN
          if (verify_q) err_d = (rdata_d != wdata_q);
`endif
        end else begin
          idx_d   = idx_q + AW'(1);
          state_d = SETUP;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so every port comes straight off a flop.
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
    mem_we_d = (state_d == STROBE);
    addr_d   = (state_d == IDLE || state_d == DONE) ? '0 : idx_d;
    mem_d_d  = (state_d == SETUP || state_d == STROBE || state_d == SAMPLE) ?
               wdata_d[idx_d] : 1'b0;
  end

  always_ff @(posedge clk) begin
    wr_q    <= wr_d;
    wdata_q <= wdata_d;
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rdata    <= '0;
      mem_addr <= '0;
      mem_d    <= 1'b0;
      mem_we   <= 1'b0;
`ifdef RAM_SEQ_VERIFY_EN
      verify_q <= 1'b0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      busy     <= busy_d;
      done     <= done_d;
      rdata    <= rdata_d;
      mem_addr <= addr_d;
      mem_d    <= mem_d_d;
      mem_we   <= mem_we_d;
`ifdef RAM_SEQ_VERIFY_EN
      verify_q <= verify_d;
      err_q    <= err_d;
`endif
    end
  end

endmodule
